// File: rtl/timestamp_assembler_if.sv
// Upstream FWFT FIFO pop port plus the assembled-timestamp valid/ready stream.
interface timestamp_assembler_if;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;
  logic [47:0] TS_DATA;
  logic        TS_VALID;
  logic        TS_READY;

  // Assembler side: pops the FIFO and sources the timestamp stream.
  modport master (
    input  FIFO_EMPTY, FIFO_DATA, TS_READY,
    output FIFO_READ, TS_DATA, TS_VALID
  );

  // Environment side: FIFO owner and timestamp consumer.
  modport slave (
    output FIFO_EMPTY, FIFO_DATA, TS_READY,
    input  FIFO_READ, TS_DATA, TS_VALID
  );
endinterface

// File: rtl/timestamp_assembler.sv
// Reassembles high/low 32-bit capture words into 48-bit timestamps on a
// valid/ready stream, with identifier, ordering and monotonicity error counters.
module timestamp_assembler #(
  parameter logic [6:0]  IDENTIFIER = 7'b0000001,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                   BUS_CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   CNT_CLR,
  timestamp_assembler_if.master  bus,
  output logic [CNT_WIDTH-1:0]   ID_ERR_CNT,
  output logic [CNT_WIDTH-1:0]   SEQ_ERR_CNT,
  output logic [CNT_WIDTH-1:0]   MONO_ERR_CNT
);

  localparam int unsigned HALF_W = 24;
  localparam int unsigned TS_W   = 2 * HALF_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                out_free;
  logic                id_ok;
  logic                is_high;
  logic                pop;
  logic                load_high;
  logic                emit;
  logic                id_err;
  logic                seq_err;
  logic                mono_err;
  logic [HALF_W-1:0]   high_buf;
  logic [TS_W-1:0]     new_ts;
  logic [TS_W-1:0]     prev_ts;
  logic                prev_valid;

  assign out_free = !bus.TS_VALID || bus.TS_READY;
  assign id_ok    = (bus.FIFO_DATA[31:25] == IDENTIFIER);
  assign is_high  = bus.FIFO_DATA[24];
  assign new_ts   = {high_buf, bus.FIFO_DATA[HALF_W-1:0]};
  assign mono_err = emit && prev_valid && (new_ts <= prev_ts);
  assign bus.FIFO_READ = pop;

  // State register
  always_ff @(posedge BUS_CLK) begin
    if (RST) state <= WAIT_HIGH;
    else     state <= state_nxt;
  end

  // Next-state logic; bad-identifier words never move the FSM
  always_comb begin
    state_nxt = state;
    if (pop && id_ok) begin
      case (state)
        WAIT_HIGH: if (is_high)  state_nxt = WAIT_LOW;
        WAIT_LOW:  if (!is_high) state_nxt = WAIT_HIGH;
        default:   state_nxt = WAIT_HIGH;
      endcase
    end
  end

  // Pop decision and per-word action decode
  always_comb begin
    pop       = 1'b0;
    load_high = 1'b0;
    emit      = 1'b0;
    id_err    = 1'b0;
    seq_err   = 1'b0;
    pop = !RST && EN && !bus.FIFO_EMPTY && ((state == WAIT_HIGH) || out_free);
    if (pop) begin
      if (!id_ok) begin
        id_err = 1'b1;
      end else begin
        case (state)
          WAIT_HIGH: begin
            if (is_high) load_high = 1'b1;
            else         seq_err   = 1'b1;
          end
          WAIT_LOW: begin
            if (is_high) begin
              load_high = 1'b1;
              seq_err   = 1'b1;
            end else begin
              emit = 1'b1;
            end
          end
          default: seq_err = 1'b0;
        endcase
      end
    end
  end

  // Pair buffer and monotonicity history
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      high_buf   <= '0;
      prev_ts    <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (load_high) high_buf <= bus.FIFO_DATA[HALF_W-1:0];
      if (emit) begin
        prev_ts    <= new_ts;
        prev_valid <= 1'b1;
      end
    end
  end

  // Output stream register; a new load wins over a completing transfer
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      bus.TS_VALID <= 1'b0;
      bus.TS_DATA  <= '0;
    end else if (emit) begin
      bus.TS_VALID <= 1'b1;
      bus.TS_DATA  <= new_ts;
    end else if (bus.TS_READY) begin
      bus.TS_VALID <= 1'b0;
    end
  end

  // Saturating error counters; clear has priority
  always_ff @(posedge BUS_CLK) begin
    if (RST || CNT_CLR) begin
      ID_ERR_CNT   <= '0;
      SEQ_ERR_CNT  <= '0;
      MONO_ERR_CNT <= '0;
    end else begin
      if (id_err && (ID_ERR_CNT != CNT_MAX))
        ID_ERR_CNT <= ID_ERR_CNT + CNT_WIDTH'(1);
      if (seq_err && (SEQ_ERR_CNT != CNT_MAX))
        SEQ_ERR_CNT <= SEQ_ERR_CNT + CNT_WIDTH'(1);
      if (mono_err && (MONO_ERR_CNT != CNT_MAX))
        MONO_ERR_CNT <= MONO_ERR_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_timestamp_assembler.sv
// Scoreboard bench for timestamp_assembler: FIFO model, word-level reference
// model, decoupled output monitor, directed cases then randomized traffic.
module tb_timestamp_assembler;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_SAT = 255;
  localparam int unsigned MEM_D   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] id_cnt, seq_cnt, mono_cnt;

  timestamp_assembler_if dif ();

  timestamp_assembler #(.IDENTIFIER(7'b0000001), .CNT_WIDTH(CNT_W)) dut (
    .BUS_CLK      (clk),
    .RST          (rst),
    .EN           (en),
    .CNT_CLR      (cnt_clr),
    .bus          (dif),
    .ID_ERR_CNT   (id_cnt),
    .SEQ_ERR_CNT  (seq_cnt),
    .MONO_ERR_CNT (mono_cnt)
  );

  always #5 clk = ~clk;

  // Upstream FWFT FIFO model
  logic [31:0] mem [0:MEM_D-1];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign dif.FIFO_EMPTY = (rd_ptr == wr_ptr);
  assign dif.FIFO_DATA  = mem[rd_ptr[11:0]];
  always @(posedge clk) if (dif.FIFO_READ) rd_ptr <= rd_ptr + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: processes the word stream in order
  logic [47:0] exp_q[$];
  bit          m_have_high = 0;
  logic [23:0] m_high = '0;
  bit          m_prev_valid = 0;
  logic [47:0] m_prev = '0;
  int          m_id = 0, m_seq = 0, m_mono = 0;

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : CNT_SAT;
  endfunction

  function automatic void model_reset();
    m_have_high = 0; m_high = '0; m_prev_valid = 0; m_prev = '0;
    m_id = 0; m_seq = 0; m_mono = 0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    logic [47:0] ts;
    if (w[31:25] != 7'd1) begin
      m_id = sat_inc(m_id);
    end else if (w[24]) begin
      if (m_have_high) m_seq = sat_inc(m_seq);
      m_have_high = 1;
      m_high = w[23:0];
    end else if (!m_have_high) begin
      m_seq = sat_inc(m_seq);
    end else begin
      ts = {m_high, w[23:0]};
      if (m_prev_valid && ts <= m_prev) m_mono = sat_inc(m_mono);
      m_prev = ts;
      m_prev_valid = 1;
      m_have_high = 0;
      exp_q.push_back(ts);
    end
  endfunction

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr = wr_ptr + 1;
    model_word(w);
  endtask

  task automatic push_pair(input logic [23:0] hi, input logic [23:0] lo);
    push({7'd1, 1'b1, hi});
    push({7'd1, 1'b0, lo});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout, got no completion expected completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, "_id_cnt"},   64'(id_cnt),   64'(m_id));
    check({tag, "_seq_cnt"},  64'(seq_cnt),  64'(m_seq));
    check({tag, "_mono_cnt"}, 64'(mono_cnt), 64'(m_mono));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    en = 1'b1;
    dif.TS_READY = 1'b1;
    while (!(rd_ptr == wr_ptr && exp_q.size() == 0 && !dif.TS_VALID) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail("drain");
  endtask

  task automatic wait_popped(input int budget);
    int n = 0;
    while (rd_ptr != wr_ptr && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail("wait_popped");
  endtask

  // Monitor: compares every transfer against the scoreboard, and checks hold under stall
  bit          stall_prev = 0;
  logic [47:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 0;
    end else begin
      if (stall_prev) check("ts_hold", 64'(dif.TS_DATA), 64'(held));
      if (dif.TS_VALID && dif.TS_READY) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ts_unexpected: got %0h expected no output", dif.TS_DATA);
        end else begin
          check("ts_data", 64'(dif.TS_DATA), 64'(exp_q.pop_front()));
        end
      end
      stall_prev <= dif.TS_VALID && !dif.TS_READY;
      held <= dif.TS_DATA;
    end
  end

  initial begin
    dif.TS_READY = 1'b0;
    model_reset();

    // Reset state, and a word waiting during reset must not be popped
    step();
    push(32'h0300_00AB);
    step();
    @(negedge clk);
    check("rst_fifo_read", 64'(dif.FIFO_READ), 64'd0);
    check("rst_ts_valid",  64'(dif.TS_VALID),  64'd0);
    check("rst_ts_data",   64'(dif.TS_DATA),   64'd0);
    check_counters("rst");
    step();
    rst = 1'b0;
    en = 1'b1;
    dif.TS_READY = 1'b1;

    // Basic pair
    push(32'h0200_1234);
    drain(100);
    check_counters("basic");

    // Output stall: only the next high word may be taken
    dif.TS_READY = 1'b0;
    push(32'h0300_0001);
    push(32'h0200_0005);
    wait_popped(50);
    repeat (10) step();
    @(negedge clk);
    check("stall_valid", 64'(dif.TS_VALID), 64'd1);
    check("stall_data",  64'(dif.TS_DATA),  64'h0000_0001_0000_05);
    step();
    push(32'h0300_0002);
    push(32'h0200_0006);
    repeat (10) step();
    @(negedge clk);
    check("stall_pending_words", 64'(wr_ptr - rd_ptr), 64'd1);
    check("stall_fifo_read",     64'(dif.FIFO_READ),   64'd0);
    step();
    dif.TS_READY = 1'b1;
    @(negedge clk);
    check("unstall_fifo_read", 64'(dif.FIFO_READ), 64'd1);
    drain(100);
    check_counters("stall");

    // Bad identifier
    step();
    push(32'h0500_0001);
    drain(100);
    check_counters("badid");

    // Ordering violations
    step();
    push(32'h0200_0007);
    push(32'h0300_0001);
    push(32'h0300_0002);
    push(32'h0200_0003);
    drain(100);
    check_counters("seq");

    // Monotonicity, including 48-bit drop
    step();
    push_pair(24'h000001, 24'h000010);
    push_pair(24'h000001, 24'h000010);
    push_pair(24'h000000, 24'hFFFFFF);
    drain(100);
    check_counters("mono");

    // Saturation then clear
    step();
    for (int i = 0; i < 300; i++) push(32'h0500_0001);
    drain(1000);
    check_counters("sat");
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    m_id = 0; m_seq = 0; m_mono = 0;
    check_counters("clr");

    // Reset between high and low word
    step();
    push(32'h0300_0004);
    drain(100);
    step();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    push(32'h0200_0009);
    drain(100);
    @(negedge clk);
    check("midrst_ts_valid", 64'(dif.TS_VALID), 64'd0);
    check_counters("midrst");

    // Randomized traffic with random EN and TS_READY
    for (int c = 0; c < 1500; c++) begin
      step();
      en = ($urandom_range(0, 3) != 0);
      dif.TS_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && wr_ptr < MEM_D - 8) begin
        logic [6:0]  rid;
        logic [23:0] val;
        rid = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'd1;
        val = 24'($urandom);
        push({rid, ($urandom_range(0, 2) != 0) ? (c[0] ? 1'b1 : 1'b0) : 1'($urandom), val});
      end
    end
    drain(3000);
    check_counters("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
